// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared polynomial-memory parameters and bank mapping
//
// Purpose: constants common to the bank read and write paths, the reader FSM
//          state type, and bank_rot(), the single definition of the
//          conflict-free bank rotation.
// Ports:   none (package).
`ifndef D_width
`define D_width 16
`endif

package ntt_pkg;

  localparam int BN      = 16;
  localparam int D_WIDTH = `D_width;
  localparam int ADDR_W  = 9;
  localparam int ROT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } rd_state_e;

  // Coefficient k lives in bank (k[3:0] + bank_rot(k>>4)) mod 16.
  // The row is zero-extended to three nibbles and the nibbles are summed mod 16.
  function automatic logic [ROT_W-1:0] bank_rot(input logic [ADDR_W-1:0] row);
    logic [11:0] r12;
    r12 = 12'(row);
    return r12[3:0] + r12[7:4] + r12[11:8];
  endfunction

endpackage

// File: rtl/ntt_bank_reader_if.sv
// rtl/ntt_bank_reader_if.sv - coefficient-row output stream
//
// Purpose: valid/ready stream carrying one de-rotated row of BN coefficients.
// Signals: out_valid (beat available), out_ready (sink accepts),
//          out_data (BN lanes of D_WIDTH), out_row (row index of the beat).
interface ntt_bank_reader_if;
  import ntt_pkg::*;

  logic                    out_valid;
  logic                    out_ready;
  logic [BN*D_WIDTH-1:0]   out_data;
  logic [ADDR_W-1:0]       out_row;

  modport master (output out_valid, output out_data, output out_row, input out_ready);
  modport slave  (input out_valid, input out_data, input out_row, output out_ready);

endinterface

// File: rtl/ntt_bank_reader_lane_rotator.sv
// rtl/ntt_bank_reader_lane_rotator.sv - combinational lane barrel rotator
//
// Purpose: output lane j takes input lane (j + amt_i) mod LANES.
// Ports:   data_i (LANES*W packed lanes), amt_i (rotate amount),
//          data_o (rotated lanes).
module lane_rotator #(
  parameter int LANES = 16,
  parameter int W     = 16,
  parameter int AMT_W = 4
) (
  input  logic [LANES*W-1:0] data_i,
  input  logic [AMT_W-1:0]   amt_i,
  output logic [LANES*W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int j = 0; j < LANES; j++) begin
      data_o[j*W +: W] = data_i[((j + int'(amt_i)) % LANES)*W +: W];
    end
  end

endmodule

// File: rtl/ntt_bank_reader.sv
// rtl/ntt_bank_reader.sv - streams the banked polynomial memory in natural order
//
// Purpose: reads rows 0..row_count-1 from the BN SRAM banks (shared A-port
//          address), de-rotates each returned row and emits it on a
//          valid/ready stream through a 2-entry buffer.
// Ports:   clk, rst (async, active high); start/row_count (command);
//          busy/done (status); rd_cen/rd_addr/rd_wen/rd_data (bank A ports);
//          out (ntt_bank_reader_if master: out_valid/out_ready/out_data/out_row).
module ntt_bank_reader
  import ntt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       row_count,
  output logic                  busy,
  output logic                  done,
  output logic [BN-1:0]         rd_cen,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_wen,
  input  logic [BN*D_WIDTH-1:0] rd_data,
  ntt_bank_reader_if.master     out
);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     issue_row_q, issue_row_d;
  logic [ADDR_W:0]       rows_left_q, rows_left_d;

  // Read issued last cycle; its row and rotation travel with it so the
  // returning data is de-rotated with the matching amount.
  logic                  inflight_q;
  logic [ADDR_W-1:0]     pend_row_q;
  logic [ROT_W-1:0]      pend_rot_q;

  logic [ADDR_W-1:0]     row_mem_q  [2];
  logic [BN*D_WIDTH-1:0] data_mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  credit;
  logic [1:0]            occ;
  logic [BN*D_WIDTH-1:0] rotated;

  lane_rotator #(
    .LANES (BN),
    .W     (D_WIDTH),
    .AMT_W (ROT_W)
  ) u_rot (
    .data_i (rd_data),
    .amt_i  (pend_rot_q),
    .data_o (rotated)
  );

  assign push = inflight_q;
  assign pop  = (count_q != 2'd0) && out.out_ready;
  assign occ  = {1'b0, inflight_q} + count_q;
  // SRAM data cannot be stalled, so a row is only issued when a buffer slot
  // is guaranteed for it; a same-cycle pop frees one.
  assign credit = (occ < 2'd2) || ((occ == 2'd2) && pop);

  always_comb begin
    state_d     = state_q;
    issue_row_d = issue_row_q;
    rows_left_d = rows_left_q;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d     = ST_RUN;
            issue_row_d = '0;
            rows_left_d = row_count;
          end
        end
      end
      ST_RUN: begin
        if (credit) begin
          issue       = 1'b1;
          issue_row_d = issue_row_q + 1'b1;
          rows_left_d = rows_left_q - 1'b1;
          if (rows_left_q == 1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the final beat is accepted so done follows it directly.
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_row_q <= '0;
      rows_left_q <= '0;
      inflight_q  <= 1'b0;
      pend_row_q  <= '0;
      pend_rot_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        row_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      issue_row_q <= issue_row_d;
      rows_left_q <= rows_left_d;
      inflight_q  <= issue;
      if (issue) begin
        pend_row_q <= issue_row_q;
        pend_rot_q <= bank_rot(issue_row_q);
      end
      if (push) begin
        row_mem_q[wr_ptr_q]  <= pend_row_q;
        data_mem_q[wr_ptr_q] <= rotated;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == 2'd2)))
        else $error("ntt_bank_reader: output buffer overflow");
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);
  assign rd_cen        = issue ? '0 : '1;
  assign rd_addr       = issue_row_q;
  assign rd_wen        = 1'b1;
  assign out.out_valid = (count_q != 2'd0);
  assign out.out_data  = data_mem_q[rd_ptr_q];
  assign out.out_row   = row_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ntt_bank_reader.sv
// tb/tb_ntt_bank_reader.sv - directed self-checking bench for ntt_bank_reader
module tb_ntt_bank_reader;
  import ntt_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_W:0]       row_count;
  logic                  busy;
  logic                  done;
  logic [BN-1:0]         rd_cen;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_wen;
  logic [BN*D_WIDTH-1:0] rd_data;

  ntt_bank_reader_if bus ();

  ntt_bank_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_count (row_count),
    .busy      (busy),
    .done      (done),
    .rd_cen    (rd_cen),
    .rd_addr   (rd_addr),
    .rd_wen    (rd_wen),
    .rd_data   (rd_data),
    .out       (bus)
  );

  always #5 clk = ~clk;

  // Bank memories: synchronous read on the A port, data valid the next cycle.
  logic [D_WIDTH-1:0] mem [BN][512];
  always @(posedge clk) begin
    for (int b = 0; b < BN; b++) begin
      if (!rd_cen[b]) rd_data[b*D_WIDTH +: D_WIDTH] <= mem[b][rd_addr];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Run statistics
  int beats, bad_order, bad_data, done_cycle, done_count, first_valid, first_issue;
  int issues, issues_early, credit_viol, unstable, valid_ever;
  logic [D_WIDTH-1:0] lane0_111, lane13_111;

  function automatic int tb_rot(input int r);
    return (((r >> 8) & 15) + ((r >> 4) & 15) + (r & 15)) % 16;
  endfunction

  task automatic check(input string tag, input logic [BN*D_WIDTH-1:0] obs,
                       input logic [BN*D_WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return (c % 3) == 0;
      2:       return c >= 20;
      default: return 1'b1;
    endcase
  endfunction

  // Starts a readout at the current cycle (cycle 0) and monitors it until
  // two cycles past done, or until max_cycles elapse.
  task automatic run(input int rows, input int mode, input int max_cycles);
    int held;
    logic pop;
    logic prev_stall;
    logic [BN*D_WIDTH-1:0] prev_data;
    logic [ADDR_W-1:0] prev_row;
    beats = 0; bad_order = 0; bad_data = 0; done_cycle = -1; done_count = 0;
    first_valid = -1; first_issue = -1; issues = 0; issues_early = 0;
    credit_viol = 0; unstable = 0; valid_ever = 0;
    held = 0; prev_stall = 1'b0; prev_data = '0; prev_row = '0;
    start = 1'b1;
    row_count = (ADDR_W+1)'(rows);
    for (int c = 0; c < max_cycles; c++) begin
      bus.out_ready = ready_for(mode, c);
      @(negedge clk);
      pop = bus.out_valid && bus.out_ready;
      if (rd_cen != '1) begin
        issues++;
        if (first_issue < 0) first_issue = c;
        if (c < 20) issues_early++;
        if (!(held < 2 || (held == 2 && pop))) credit_viol++;
        held++;
      end
      if (prev_stall && (bus.out_data !== prev_data || bus.out_row !== prev_row)) unstable++;
      if (bus.out_valid) begin
        valid_ever = 1;
        if (first_valid < 0) first_valid = c;
      end
      if (pop) begin
        if (bus.out_row !== ADDR_W'(beats)) bad_order++;
        for (int j = 0; j < BN; j++) begin
          if (bus.out_data[j*D_WIDTH +: D_WIDTH] !== D_WIDTH'(16*beats + j)) bad_data++;
        end
        if (beats == 'h111) begin
          lane0_111  = bus.out_data[0 +: D_WIDTH];
          lane13_111 = bus.out_data[13*D_WIDTH +: D_WIDTH];
        end
        beats++;
        held--;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_row   = bus.out_row;
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
  endtask

  initial begin
    int cen_busy;
    rst = 1'b1;
    start = 1'b0;
    row_count = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < BN*512; k++) begin
      mem[(k % 16 + tb_rot(k / 16)) % 16][k / 16] = D_WIDTH'(k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_cen", rd_cen, {BN{1'b1}});
    check("rst_addr", rd_addr, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_row", bus.out_row, 0);
    check("rd_wen", rd_wen, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full memory, sink always ready
    run(512, 0, 600);
    check("full_first_issue", first_issue, 1);
    check("full_first_valid", first_valid, 3);
    check("full_beats", beats, 512);
    check("full_order", bad_order, 0);
    check("full_data", bad_data, 0);
    check("full_done_cycle", done_cycle, 515);
    check("full_done_count", done_count, 1);
    check("full_credit", credit_viol, 0);
    check("row111_lane0", lane0_111, 'h1110);
    check("row111_lane13", lane13_111, 'h111d);

    // Sink ready pattern 1,0,0 repeating
    run(4, 1, 100);
    check("toggle_beats", beats, 4);
    check("toggle_order", bad_order, 0);
    check("toggle_data", bad_data, 0);
    check("toggle_stable", unstable, 0);
    check("toggle_credit", credit_viol, 0);
    check("toggle_done_cycle", done_cycle, 13);

    // Sink held off for 20 cycles
    run(8, 2, 100);
    check("stall_issues", issues_early, 2);
    check("stall_beats", beats, 8);
    check("stall_data", bad_data, 0);
    check("stall_stable", unstable, 0);
    check("stall_done_cycle", done_cycle, 28);

    // Zero rows; a start during the done cycle must be ignored
    cen_busy = 0;
    valid_ever = 0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    row_count = '0;
    @(negedge clk);
    if (rd_cen != '1) cen_busy++;
    if (bus.out_valid) valid_ever = 1;
    @(posedge clk);
    #1;
    start = 1'b1;
    row_count = 3;
    @(negedge clk);
    check("zero_done_c1", done, 1);
    if (rd_cen != '1) cen_busy++;
    if (bus.out_valid) valid_ever = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_busy_c2", busy, 0);
    check("zero_done_c2", done, 0);
    for (int c = 0; c < 4; c++) begin
      if (rd_cen != '1) cen_busy++;
      if (bus.out_valid) valid_ever = 1;
      @(negedge clk);
    end
    check("zero_no_cen", cen_busy, 0);
    check("zero_no_valid", valid_ever, 0);
    @(posedge clk);
    #1;

    // Reset in cycle 5 of a 64-row run
    done_count = 0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    row_count = 64;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) done_count++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cen", rd_cen, {BN{1'b1}});
    check("arst_valid", bus.out_valid, 0);
    check("arst_addr", rd_addr, 0);
    check("arst_row", bus.out_row, 0);
    check("arst_data", bus.out_data, 0);
    @(negedge clk);
    if (done) done_count++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    if (done) done_count++;
    check("arst_no_done", done_count, 0);
    @(posedge clk);
    #1;
    run(2, 0, 50);
    check("post_rst_beats", beats, 2);
    check("post_rst_order", bad_order, 0);
    check("post_rst_data", bad_data, 0);
    check("post_rst_done", done_cycle, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
